ctrl_pipe_reg: RTL and testbench
================================

Name: ctrl_pipe_reg

Overview:
Parametrised pipeline register chain carrying a control bundle plus a data payload through DEPTH stages. It is the successor to the fixed 7-bit EX/MEM control latch. Each stage has a valid bit and a per-stage flush that inserts a bubble. A global stall freezes the chain, and a saturating counter tracks bubble cycles for performance monitoring. It is used between any two pipeline stages (ID/EX, EX/MEM, MEM/WB) in place of hand-written latches.

Parameters:
CTRL_W, 7, width of control bundle (RegWrite, MemtoReg, Jump, JumpReg, Branch, MemRead, MemWrite packed LSB-first)
DATA_W, 32, width of data payload
DEPTH, 1, number of chained register stages (legal 1..4)
CNT_W, 16, width of bubble counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
stall  in  1  freeze all stages this cycle
flush  in  DEPTH  per-stage bubble insert; bit i targets stage i (stage 0 is nearest the input)
in_valid  in  1  input bundle is a real instruction
in_ctrl  in  CTRL_W  input control bundle
in_data  in  DATA_W  input payload
out_valid  out  1  valid of stage DEPTH-1
out_ctrl  out  CTRL_W  control of stage DEPTH-1; all zero whenever out_valid=0
out_data  out  DATA_W  payload of stage DEPTH-1
cnt_clr  in  1  synchronous clear of bubble counter
bubble_cnt  out  CNT_W  saturating count of bubble cycles at output

Behaviour:
- Reset (reset=0, asynchronous): every stage has valid=0, ctrl=0, data=0. bubble_cnt=0. Outputs reflect this immediately, without waiting for a clock edge.
- Stage i source: stage 0 loads {in_valid, in_ctrl, in_data}; stage i>0 loads stage i-1.
- Per-stage update at each posedge, in priority order:
  1. flush[i]=1: valid_i=0, ctrl_i=0, data_i holds its own previous value.
  2. else if stall=1: stage i holds all fields.
  3. else: stage i loads its source.
- Control gating: if the loaded valid is 0, ctrl is forced to 0. In-flight ctrl is therefore never non-zero in a bubble, even when in_ctrl is non-zero with in_valid=0.
- Flush beats stall. Flushing stage i during a stall bubbles stage i only; all other stages hold.
- Flush on stage i does not affect what stage i+1 captures on the same edge: stage i+1 takes stage i's pre-edge contents.
- Latency: in_* appears on out_* exactly DEPTH non-stalled edges later. There is no combinational path from inputs to outputs.
- Bubble counter, at each posedge outside reset:
  - cnt_clr=1: bubble_cnt=0 (takes priority over increment).
  - else if stall=0 and out_valid=0 (pre-edge value): increment by 1, saturating at 2^CNT_W-1 with no wrap.
  - Stalled cycles are never counted.
- Reset asserted mid-operation discards all in-flight bundles. The first valid output after release appears DEPTH non-stalled edges after the first accepted in_valid=1.
- DEPTH outside 1..4 is a compile-time error (elaboration assertion).

Decomposition:
- Shared package cpu_pipe_pkg:
  - CTRL_W default constant
  - control-bundle bit-index constants (CTRL_REGWRITE=0 … CTRL_MEMWRITE=6)
  - packed struct typedef for the 7-bit control bundle
- One natural sub-module, pipe_stage_slice: a single stage implementing the flush/stall/load priority and ctrl gating. It is instantiated DEPTH times via generate.
- The bubble counter lives in the top module.

Test Plan:
- Reset check: DEPTH=2, reset low with in_valid=1, in_ctrl=7'h7F -> out_valid=0, out_ctrl=0, bubble_cnt=0 immediately; after release, in_valid=1, ctrl=7'h25, data=32'hDEADBEEF -> appears on out_* on the 2nd posedge.
- Stall hold: DEPTH=2, stream A(ctrl 7'h01), B(ctrl 7'h02); assert stall for 3 cycles after A enters stage 0 -> outputs frozen for 3 cycles, bubble_cnt unchanged during the stall, A then B emerge in order with no loss.
- Per-stage flush: DEPTH=3, items X,Y,Z in stages 2,1,0; pulse flush=3'b010 -> next edge: stage 2=Y's predecessor shift unaffected, stage 1 bubble (ctrl=0), stage 2 gets Y; two edges later out_valid=0, out_ctrl=0.
- Flush vs stall: DEPTH=2, stall=1 and flush=2'b01 together -> stage 0 becomes bubble, stage 1 holds its valid item, out unchanged that cycle.
- Ctrl gating: in_valid=0, in_ctrl=7'h7F, DEPTH=1 -> out_valid=0, out_ctrl=7'h00 after 1 edge.
- Counter: CNT_W=2, idle with no stall for 5 edges -> bubble_cnt goes 1,2,3,3,3; then cnt_clr=1 together with a bubble -> bubble_cnt=0.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the pipeline control-latch family: default control
// width, bit positions of each control signal and a named view of the bundle.
package cpu_pipe_pkg;

  localparam int CTRL_W_DEF = 7;

  // Bit positions inside the control bundle, packed LSB-first.
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_JUMP     = 2;
  localparam int CTRL_JUMPREG  = 3;
  localparam int CTRL_BRANCH   = 4;
  localparam int CTRL_MEMREAD  = 5;
  localparam int CTRL_MEMWRITE = 6;

  // Named view of the 7-bit bundle; first member is the MSB, so regWrite
  // lands on bit 0 and matches the index constants above.
  typedef struct packed {
    logic memWrite;
    logic memRead;
    logic branch;
    logic jumpReg;
    logic jump;
    logic memtoReg;
    logic regWrite;
  } ctrlBundle_t;

endpackage

// File: rtl/pipe_stage_slice.sv
// One register stage of the control/data chain. Applies the flush > stall >
// load priority and keeps ctrl at zero whenever the stage holds a bubble.
module pipe_stage_slice
  import cpu_pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              srcValid,
  input  logic [CTRL_W-1:0] srcCtrl,
  input  logic [DATA_W-1:0] srcData,
  output logic              stageValid,
  output logic [CTRL_W-1:0] stageCtrl,
  output logic [DATA_W-1:0] stageData
);

  // Stage register: flush inserts a bubble, stall holds, otherwise load source.
  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // its neighbour's pre-edge value, which is what makes the chain shift.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stageValid <= 1'b0;
      stageCtrl  <= '0;
      stageData  <= '0;
    end else if (flush) begin
      // Payload is left as-is; only valid and ctrl define a bubble.
      stageValid <= 1'b0;
      stageCtrl  <= '0;
    end else if (!stall) begin
      stageValid <= srcValid;
      stageCtrl  <= srcValid ? srcCtrl : '0;
      stageData  <= srcData;
    end
  end

endmodule

// File: rtl/ctrl_pipe_reg.sv
// Parametrised pipeline register chain for a control bundle plus payload,
// with per-stage flush, global stall and a saturating bubble counter.
module ctrl_pipe_reg
  import cpu_pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [DEPTH-1:0]  flush,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  bubble_cnt
);

  if (DEPTH < 1 || DEPTH > 4) begin : gDepthCheck
    $fatal(1, "ctrl_pipe_reg: DEPTH must be within 1..4");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              stgValid [DEPTH];
  logic [CTRL_W-1:0] stgCtrl  [DEPTH];
  logic [DATA_W-1:0] stgData  [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : gStage
    logic              srcValid;
    logic [CTRL_W-1:0] srcCtrl;
    logic [DATA_W-1:0] srcData;

    if (i == 0) begin : gHead
      assign srcValid = in_valid;
      assign srcCtrl  = in_ctrl;
      assign srcData  = in_data;
    end else begin : gBody
      assign srcValid = stgValid[i-1];
      assign srcCtrl  = stgCtrl[i-1];
      assign srcData  = stgData[i-1];
    end

    pipe_stage_slice #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W)
    ) uSlice (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .flush      (flush[i]),
      .srcValid   (srcValid),
      .srcCtrl    (srcCtrl),
      .srcData    (srcData),
      .stageValid (stgValid[i]),
      .stageCtrl  (stgCtrl[i]),
      .stageData  (stgData[i])
    );
  end

  assign out_valid = stgValid[DEPTH-1];
  assign out_ctrl  = stgCtrl[DEPTH-1];
  assign out_data  = stgData[DEPTH-1];

  // Bubble counter: clear wins, otherwise count unstalled empty output cycles
  // and stop at the all-ones value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_cnt <= '0;
    end else if (cnt_clr) begin
      bubble_cnt <= '0;
    end else if (!stall && !out_valid && bubble_cnt != CNT_MAX) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ctrl_pipe_reg.sv
// Bench for ctrl_pipe_reg: three instances (DEPTH 2, DEPTH 3, DEPTH 1 with a
// 2-bit counter) share stimulus and are compared every cycle to a reference.
module tb_ctrl_pipe_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, inValid, cntClr;
  logic [6:0]  inCtrl;
  logic [31:0] inData;
  logic [1:0]  flushA;
  logic [2:0]  flushB;
  logic [0:0]  flushC;

  logic        validA, validB, validC;
  logic [6:0]  ctrlA, ctrlB, ctrlC;
  logic [31:0] dataA, dataB, dataC;
  logic [15:0] cntA, cntB;
  logic [1:0]  cntC;

  ctrl_pipe_reg #(.CTRL_W(7), .DATA_W(32), .DEPTH(2), .CNT_W(16)) dutA (
    .clk(clk), .reset(reset), .stall(stall), .flush(flushA),
    .in_valid(inValid), .in_ctrl(inCtrl), .in_data(inData),
    .out_valid(validA), .out_ctrl(ctrlA), .out_data(dataA),
    .cnt_clr(cntClr), .bubble_cnt(cntA));

  ctrl_pipe_reg #(.CTRL_W(7), .DATA_W(32), .DEPTH(3), .CNT_W(16)) dutB (
    .clk(clk), .reset(reset), .stall(stall), .flush(flushB),
    .in_valid(inValid), .in_ctrl(inCtrl), .in_data(inData),
    .out_valid(validB), .out_ctrl(ctrlB), .out_data(dataB),
    .cnt_clr(cntClr), .bubble_cnt(cntB));

  ctrl_pipe_reg #(.CTRL_W(7), .DATA_W(32), .DEPTH(1), .CNT_W(2)) dutC (
    .clk(clk), .reset(reset), .stall(stall), .flush(flushC),
    .in_valid(inValid), .in_ctrl(inCtrl), .in_data(inData),
    .out_valid(validC), .out_ctrl(ctrlC), .out_data(dataC),
    .cnt_clr(cntClr), .bubble_cnt(cntC));

  // Reference: each DUT is a list of slots holding {valid, ctrl, data}.
  typedef struct packed {
    logic        v;
    logic [6:0]  c;
    logic [31:0] d;
  } slot_t;

  slot_t       mdl  [3][4];
  int unsigned mcnt [3];
  int          errors = 0;
  int          checks = 0;

  function automatic int depOf(input int k);
    return (k == 0) ? 2 : (k == 1) ? 3 : 1;
  endfunction

  function automatic int unsigned cmaxOf(input int k);
    return (k == 2) ? 3 : 65535;
  endfunction

  function automatic logic [3:0] flOf(input int k);
    case (k)
      0:       return {2'b00, flushA};
      1:       return {1'b0, flushB};
      default: return {3'b000, flushC};
    endcase
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 3; k++) begin
      mcnt[k] = 0;
      for (int i = 0; i < 4; i++) mdl[k][i] = '0;
    end
  endtask

  // Applies one clock edge of the reference with the current inputs.
  task automatic modelEdge();
    slot_t      old [3][4];
    slot_t      src;
    logic [3:0] fl;
    int         dp;
    if (!reset) begin
      modelReset();
      return;
    end
    old = mdl;
    for (int k = 0; k < 3; k++) begin
      fl = flOf(k);
      dp = depOf(k);
      if (cntClr) mcnt[k] = 0;
      else if (!stall && !old[k][dp-1].v && mcnt[k] < cmaxOf(k)) mcnt[k] = mcnt[k] + 1;
      for (int i = 0; i < dp; i++) begin
        if (fl[i]) begin
          mdl[k][i].v = 1'b0;
          mdl[k][i].c = '0;
        end else if (!stall) begin
          src = (i == 0) ? slot_t'({inValid, inCtrl, inData}) : old[k][i-1];
          mdl[k][i].v = src.v;
          mdl[k][i].c = src.v ? src.c : 7'h00;
          mdl[k][i].d = src.d;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkDut(input string tag, input int k, input logic v, input logic [6:0] c,
                          input logic [31:0] d, input logic [15:0] cnt);
    slot_t o;
    o = mdl[k][depOf(k)-1];
    check({tag, ".valid"}, 32'(v), 32'(o.v));
    check({tag, ".ctrl"},  32'(c), 32'(o.c));
    check({tag, ".data"},  d, o.d);
    check({tag, ".cnt"},   32'(cnt), mcnt[k]);
  endtask

  task automatic checkAll();
    checkDut("A", 0, validA, ctrlA, dataA, cntA);
    checkDut("B", 1, validB, ctrlB, dataB, cntB);
    checkDut("C", 2, validC, ctrlC, dataC, {14'b0, cntC});
  endtask

  // Advance one clock: reference edge, DUT edge, then sample 1 time unit later.
  task automatic step();
    modelEdge();
    @(posedge clk);
    #1;
    checkAll();
  endtask

  task automatic drive(input logic v, input logic [6:0] c, input logic [31:0] d);
    inValid = v;
    inCtrl  = c;
    inData  = d;
  endtask

  initial begin
    // Reset asserted with a live bundle on the inputs.
    reset = 1'b0; stall = 1'b0; cntClr = 1'b0;
    flushA = '0; flushB = '0; flushC = '0;
    drive(1'b1, 7'h7F, 32'h1234_5678);
    #1;
    modelReset();
    checkAll();
    check("rst.validA", 32'(validA), 32'd0);
    check("rst.ctrlA",  32'(ctrlA),  32'd0);
    check("rst.cntA",   32'(cntA),   32'd0);
    step();
    step();
    #2 reset = 1'b1;

    // First bundle after release reaches the DEPTH=2 output on the 2nd edge.
    drive(1'b1, 7'h25, 32'hDEAD_BEEF);
    step();
    drive(1'b0, 7'h00, 32'h0);
    step();
    check("lat.validA", 32'(validA), 32'd1);
    check("lat.ctrlA",  32'(ctrlA),  32'h25);
    check("lat.dataA",  dataA,       32'hDEAD_BEEF);

    // Stall hold: A enters, then 3 stalled cycles with B waiting at the input.
    cntClr = 1'b1; step(); cntClr = 1'b0;
    drive(1'b1, 7'h01, 32'h0000_000A);
    step();
    drive(1'b1, 7'h02, 32'h0000_000B);
    stall = 1'b1;
    repeat (3) step();
    check("stall.cntA", 32'(cntA), 32'd1);
    stall = 1'b0;
    step();
    check("stall.outA", 32'(ctrlA), 32'h01);
    drive(1'b0, 7'h00, 32'h0);
    step();
    check("stall.outB", 32'(ctrlA), 32'h02);
    check("stall.dataB", dataA, 32'h0000_000B);

    // Per-stage flush on the DEPTH=3 chain: X,Y,Z in stages 2,1,0.
    drive(1'b1, 7'h11, 32'h1); step();
    drive(1'b1, 7'h12, 32'h2); step();
    drive(1'b1, 7'h13, 32'h3); step();
    drive(1'b0, 7'h00, 32'h0);
    flushB = 3'b010;
    step();
    flushB = 3'b000;
    check("flush.outY", 32'(ctrlB), 32'h12);
    step();
    check("flush.bubV", 32'(validB), 32'd0);
    check("flush.bubC", 32'(ctrlB),  32'd0);
    check("flush.bubD", dataB,       32'h2);

    // Flush together with stall on the DEPTH=2 chain.
    drive(1'b1, 7'h31, 32'hAAAA_0001); step();
    drive(1'b1, 7'h32, 32'hAAAA_0002); step();
    stall = 1'b1; flushA = 2'b01;
    step();
    check("fs.validA", 32'(validA), 32'd1);
    check("fs.ctrlA",  32'(ctrlA),  32'h31);
    stall = 1'b0; flushA = 2'b00;
    drive(1'b0, 7'h00, 32'h0);
    step();
    check("fs.bubV", 32'(validA), 32'd0);
    check("fs.bubD", dataA,       32'hAAAA_0002);

    // Ctrl gating with a non-zero bundle and in_valid low.
    drive(1'b0, 7'h7F, 32'h5555_5555);
    step();
    check("gate.validC", 32'(validC), 32'd0);
    check("gate.ctrlC",  32'(ctrlC),  32'd0);

    // Saturating 2-bit counter on the DEPTH=1 chain.
    cntClr = 1'b1; step(); cntClr = 1'b0;
    check("cnt.clr0", 32'(cntC), 32'd0);
    for (int n = 1; n <= 5; n++) begin
      step();
      check("cnt.sat", 32'(cntC), (n < 3) ? n : 3);
    end
    cntClr = 1'b1; step(); cntClr = 1'b0;
    check("cnt.clr1", 32'(cntC), 32'd0);

    // Random traffic with occasional flushes, clears and mid-run resets.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 2) != 0), 7'($urandom), $urandom);
      stall  = ($urandom_range(0, 3) == 0);
      cntClr = ($urandom_range(0, 30) == 0);
      flushA = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
      flushB = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
      flushC = ($urandom_range(0, 5) == 0) ? 1'($urandom) : 1'b0;
      step();
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b0;
        #1;
        modelReset();
        checkAll();
        #1 reset = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
